// File: rtl/contrast_pkg.sv
// Shared constants and helpers for the contrast adjustment pipeline.
// Width-dependent helpers take the width as an argument so any lane configuration can use them.
package contrast_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_FRAC_W = 5;
    localparam int PIVOT      = 1 << (DEF_DATA_W - 1);
    localparam int UNITY_GAIN = 1 << DEF_FRAC_W;

    function automatic int pivot_of(input int data_w);
        return 1 << (data_w - 1);
    endfunction

    function automatic int unity_of(input int frac_w);
        return 1 << frac_w;
    endfunction

    // Half an LSB of the fixed-point product; added before the arithmetic shift.
    function automatic int round_const(input int frac_w);
        return (frac_w > 0) ? (1 << (frac_w - 1)) : 0;
    endfunction

    function automatic logic [31:0] clamp_u(input logic signed [31:0] y, input int data_w);
        logic signed [31:0] max_v;
        max_v = (32'sd1 <<< data_w) - 32'sd1;
        if (y < 0) begin
            return '0;
        end else if (y > max_v) begin
            return max_v;
        end
        return y;
    endfunction

    function automatic logic is_clip(input logic signed [31:0] y, input int data_w);
        logic signed [31:0] max_v;
        max_v = (32'sd1 <<< data_w) - 32'sd1;
        return (y < 0) || (y > max_v);
    endfunction

endpackage

// File: rtl/contrast_lane.sv
// One channel of the contrast datapath: pivot subtract, gain multiply, round/offset/clamp.
// All three stages advance together on en; pass beats carry the raw sample through untouched.
module contrast_lane
    import contrast_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int GAIN_W = 8,
    parameter int FRAC_W = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_pass,
    input  logic [GAIN_W-1:0]        s2_gain,
    input  logic signed [DATA_W:0]   s3_offset,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_clip
);

    localparam int P_W = DATA_W + GAIN_W + 2;
    localparam int Y_W = P_W + 2;
    localparam logic signed [DATA_W:0] PIV_D = (DATA_W + 1)'(pivot_of(DATA_W));
    localparam logic signed [Y_W-1:0]  PIV_Y = Y_W'(pivot_of(DATA_W));
    localparam logic signed [Y_W-1:0]  RND_Y = Y_W'(round_const(FRAC_W));

    logic signed [DATA_W:0] d1_q, d1_d;
    logic [DATA_W-1:0]      raw1_q, raw1_d;
    logic                   pass1_q, pass1_d;
    logic signed [P_W-1:0]  p2_q, p2_d;
    logic [DATA_W-1:0]      raw2_q, raw2_d;
    logic                   pass2_q, pass2_d;
    logic [DATA_W-1:0]      out_q, out_d;
    logic                   clip_q, clip_d;

    logic signed [Y_W-1:0]  sum3, r3, y3;
    logic signed [31:0]     y32;

    always_comb begin
        sum3 = Y_W'(p2_q) + RND_Y;
        r3   = sum3 >>> FRAC_W;
        y3   = r3 + PIV_Y + Y_W'(s3_offset);
        y32  = 32'(y3);
    end

    always_comb begin
        d1_d    = d1_q;
        raw1_d  = raw1_q;
        pass1_d = pass1_q;
        p2_d    = p2_q;
        raw2_d  = raw2_q;
        pass2_d = pass2_q;
        out_d   = out_q;
        clip_d  = clip_q;
        if (en) begin
            d1_d    = $signed({1'b0, in_data}) - PIV_D;
            raw1_d  = in_data;
            pass1_d = in_pass;
            p2_d    = P_W'(d1_q) * $signed(P_W'({1'b0, s2_gain}));
            raw2_d  = raw1_q;
            pass2_d = pass1_q;
            out_d   = pass2_q ? raw2_q : DATA_W'(clamp_u(y32, DATA_W));
            clip_d  = !pass2_q && is_clip(y32, DATA_W);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d1_q    <= '0;
            raw1_q  <= '0;
            pass1_q <= 1'b0;
            p2_q    <= '0;
            raw2_q  <= '0;
            pass2_q <= 1'b0;
            out_q   <= '0;
            clip_q  <= 1'b0;
        end else begin
            d1_q    <= d1_d;
            raw1_q  <= raw1_d;
            pass1_q <= pass1_d;
            p2_q    <= p2_d;
            raw2_q  <= raw2_d;
            pass2_q <= pass2_d;
            out_q   <= out_d;
            clip_q  <= clip_d;
        end
    end

    assign out_data = out_q;
    assign out_clip = clip_q;

endmodule

// File: rtl/contrast_adjust_pipe.sv
// Multi-channel contrast/brightness pipeline: handshake, per-frame config latch and clip counter
// around CH identical lanes.
module contrast_adjust_pipe
    import contrast_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CH     = 3,
    parameter int GAIN_W = 8,
    parameter int FRAC_W = 5,
    parameter int CNT_W  = 20
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [GAIN_W-1:0]       cfg_gain,
    input  logic signed [DATA_W:0]  cfg_offset,
    input  logic                    cfg_bypass,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [CH*DATA_W-1:0]    s_data,
    input  logic                    s_sof,
    input  logic                    s_process,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [CH*DATA_W-1:0]    m_data,
    output logic                    m_sof,
    output logic [CNT_W-1:0]        clip_cnt
);

    localparam logic [GAIN_W-1:0] UNITY_G = GAIN_W'(unity_of(FRAC_W));

    // Handshake: a beat transfers on any edge where valid && ready. The whole pipe advances
    // together whenever the output slot is empty or being drained, so s_ready = m_ready || !m_valid.
    logic en, acc, load_cfg, pass0;
    logic [GAIN_W-1:0]      eff_gain;
    logic signed [DATA_W:0] eff_off;
    logic                   eff_byp;

    logic [GAIN_W-1:0]      gain_q, gain_d;
    logic signed [DATA_W:0] offset_q, offset_d;
    logic                   bypass_q, bypass_d;
    logic                   v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic                   sof1_q, sof1_d, sof2_q, sof2_d, sof3_q, sof3_d;
    logic [GAIN_W-1:0]      gain1_q, gain1_d;
    logic signed [DATA_W:0] off1_q, off1_d, off2_q, off2_d;
    logic [CNT_W-1:0]       clip_cnt_q, clip_cnt_d;

    logic [CH*DATA_W-1:0]   lane_data;
    logic [CH-1:0]          lane_clip;
    logic [CNT_W-1:0]       beat_clips;
    logic [CNT_W:0]         sum_ext;

    always_comb begin
        en       = m_ready || !v3_q;
        acc      = s_valid && en;
        load_cfg = acc && s_sof;
        // The SOF beat itself already uses the freshly presented configuration.
        eff_gain = load_cfg ? cfg_gain   : gain_q;
        eff_off  = load_cfg ? cfg_offset : offset_q;
        eff_byp  = load_cfg ? cfg_bypass : bypass_q;
        pass0    = !s_process || eff_byp;

        gain_d   = eff_gain;
        offset_d = eff_off;
        bypass_d = eff_byp;

        v1_d = v1_q;  v2_d = v2_q;  v3_d = v3_q;
        sof1_d = sof1_q;  sof2_d = sof2_q;  sof3_d = sof3_q;
        gain1_d = gain1_q;  off1_d = off1_q;  off2_d = off2_q;
        if (en) begin
            v1_d    = s_valid;
            sof1_d  = s_valid && s_sof;
            gain1_d = eff_gain;
            off1_d  = eff_off;
            v2_d    = v1_q;
            sof2_d  = sof1_q;
            off2_d  = off1_q;
            v3_d    = v2_q;
            sof3_d  = sof2_q;
        end
    end

    always_comb begin
        beat_clips = '0;
        for (int i = 0; i < CH; i++) begin
            beat_clips = beat_clips + CNT_W'(lane_clip[i]);
        end
        sum_ext    = {1'b0, clip_cnt_q} + {1'b0, beat_clips};
        clip_cnt_d = clip_cnt_q;
        if (v3_q && m_ready) begin
            if (sof3_q) begin
                clip_cnt_d = beat_clips;
            end else begin
                clip_cnt_d = sum_ext[CNT_W] ? '1 : sum_ext[CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gain_q     <= UNITY_G;
            offset_q   <= '0;
            bypass_q   <= 1'b0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            v3_q       <= 1'b0;
            sof1_q     <= 1'b0;
            sof2_q     <= 1'b0;
            sof3_q     <= 1'b0;
            gain1_q    <= UNITY_G;
            off1_q     <= '0;
            off2_q     <= '0;
            clip_cnt_q <= '0;
        end else begin
            gain_q     <= gain_d;
            offset_q   <= offset_d;
            bypass_q   <= bypass_d;
            v1_q       <= v1_d;
            v2_q       <= v2_d;
            v3_q       <= v3_d;
            sof1_q     <= sof1_d;
            sof2_q     <= sof2_d;
            sof3_q     <= sof3_d;
            gain1_q    <= gain1_d;
            off1_q     <= off1_d;
            off2_q     <= off2_d;
            clip_cnt_q <= clip_cnt_d;
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_lane
        contrast_lane #(
            .DATA_W (DATA_W),
            .GAIN_W (GAIN_W),
            .FRAC_W (FRAC_W)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .en        (en),
            .in_data   (s_data[g*DATA_W +: DATA_W]),
            .in_pass   (pass0),
            .s2_gain   (gain1_q),
            .s3_offset (off2_q),
            .out_data  (lane_data[g*DATA_W +: DATA_W]),
            .out_clip  (lane_clip[g])
        );
    end

    assign s_ready  = en;
    assign m_valid  = v3_q;
    assign m_sof    = sof3_q;
    assign m_data   = lane_data;
    assign clip_cnt = clip_cnt_q;

endmodule

// File: doc/contrast_adjust_pipe.md
Name: contrast_adjust_pipe

Overview:
- Parametrised successor of the single-channel point contrast block.
- Applies per-frame gain about a mid-grey pivot, then a signed brightness offset, with rounding and saturation, to CH packed channels per beat.
- Uses a valid/ready stream and passes header bytes through untouched.
- Sits between the BMP/pixel byte source and the frame writer; also counts saturated samples per frame.

Parameters:
- DATA_W, 8, bits per channel sample
- CH, 3, channels packed per beat (channel 0 in LSBs)
- GAIN_W, 8, unsigned gain width
- FRAC_W, 5, fractional bits of gain; unity gain = 1<<FRAC_W
- CNT_W, 20, clip counter width

Ports:
- clk  in  1  clock; sole clock domain
- rst  in  1  reset, synchronous, active-high
- cfg_gain  in  GAIN_W  gain; sampled on accepted SOF beat
- cfg_offset  in  DATA_W+1  signed offset; sampled on accepted SOF beat
- cfg_bypass  in  1  1 = pass pixels unchanged; sampled on accepted SOF beat
- s_valid  in  1  input beat valid
- s_ready  out  1  input accept
- s_data  in  CH*DATA_W  input samples
- s_sof  in  1  first beat of frame
- s_process  in  1  1 = pixel beat, 0 = header beat (raw pass-through)
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream accept
- m_data  out  CH*DATA_W  output samples
- m_sof  out  1  SOF aligned with m_data
- clip_cnt  out  CNT_W  saturated samples since the last output SOF, inclusive

Behaviour:
- Reset (sync, rst=1 at posedge): m_valid=0, m_data=0, m_sof=0, clip_cnt=0. All pipeline valids cleared; in-flight beats dropped. Latched cfg = gain 1<<FRAC_W, offset 0, bypass 0.
- Transfer: a beat moves when valid&&ready on the same edge.
- s_ready = m_ready || !m_valid (global-stall pipeline).
- While stalled, all stages hold and m_data/m_sof stay stable.
- Latency: exactly 3 cycles from accepted input to m_valid when there is no stall. Throughput 1 beat/cycle.
- Config latch: on an accepted beat with s_sof=1, cfg_* are registered and that beat already uses the new values. Mid-frame cfg changes are ignored until the next SOF.
- Per channel, pipeline stages (PIVOT = 1<<(DATA_W-1)):
  - S1: d = in - PIVOT, signed DATA_W+1.
  - S2: p = d * gain, signed DATA_W+GAIN_W+2.
  - S3: r = (p + (1<<(FRAC_W-1))) >>> FRAC_W (round half up); y = r + PIVOT + offset; out = clamp(y, 0, 2^DATA_W-1).
- A channel clips when y<0 or y>2^DATA_W-1.
- Header beat (s_process=0) or latched bypass=1: data passes through the same 3 stages unchanged and never counts as clipped.
- clip_cnt:
  - Adds the number of clipped channels (0..CH) of each transferred output beat.
  - On an output SOF transfer it loads that beat's clip count instead of adding.
  - Saturates at 2^CNT_W-1; no wrap.
- Simultaneous input SOF and output SOF: independent; the latch and counter actions both occur.
- s_sof on a beat that is not accepted: no latch.
- rst asserted mid-frame: outputs drop next edge. The next frame must begin with SOF; until then pixels use the unity defaults.

Decomposition:
- Shared package contrast_pkg holds:
  - PIVOT and UNITY_GAIN constants, derived from DATA_W and FRAC_W.
  - Saturate/clamp function.
  - Rounding-constant function.
- Sub-module contrast_lane: a single-channel 3-stage datapath with stall enable and a clip flag output.
- The top instantiates CH lanes via generate and owns the handshake, cfg latch and clip counter.

Test Plan:
- Gain 64, offset 0, pixel in 0xC8,0x64,0x80 -> out 0xFF,0x48,0x80; clip_cnt=1 after beat; first m_valid 3 cycles after accept.
- Gain 48, offset 0, in 129/127 -> 130/127 (rounding, −1.5 → −1); gain 32, offset −200, in 100 -> 0, clip counted.
- Header beats 0x42,0x4D with s_process=0, gain 255 -> out 0x42,0x4D unchanged, clip_cnt unchanged.
- Change cfg_gain mid-frame from 64 to 32 -> pixels keep gain 64 until next SOF; the SOF beat itself uses 32.
- Continuous stream, m_ready low 5 cycles mid-burst -> s_ready low, m_data stable, no beat lost or duplicated; order preserved across 100 random beats versus reference model.
- rst high 1 cycle with 2 beats in flight -> m_valid=0, clip_cnt=0 next edge; following SOF frame processed correctly.
